// File: rtl/npu_acc_requant.sv
// npu_acc_requant: accumulate psum beats plus bias, then scale, shift, ReLU and int8-saturate onto a valid/ready stream.
// Define NPU_REQUANT_ROUND_EN to build round-half-up shifting; the default build truncates toward -inf.
module npu_acc_requant #(
   parameter int CH_NUM      = 18,
   parameter int PSUM_WIDTH  = 24,
   parameter int ACC_WIDTH   = 32,
   parameter int BIAS_WIDTH  = 16,
   parameter int SCALE_WIDTH = 16,
   parameter int SHIFT_WIDTH = 5,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [CH_NUM*PSUM_WIDTH-1:0]    psum_in,
   input  logic                            psum_valid,
   output logic                            psum_ready,
   input  logic [7:0]                      cfg_acc_num,
   input  logic [CH_NUM*BIAS_WIDTH-1:0]    cfg_bias,
   input  logic [CH_NUM*SCALE_WIDTH-1:0]   cfg_scale,
   input  logic [SHIFT_WIDTH-1:0]          cfg_shift,
   input  logic                            cfg_relu,
   output logic [CH_NUM*DATA_WIDTH-1:0]    data_out,
   output logic                            data_valid,
   input  logic                            data_ready,
   output logic                            busy
);
   localparam int PW = ACC_WIDTH + SCALE_WIDTH + 1;
   localparam logic signed [PW-1:0] L_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] L_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic                          w_stall, w_accept, w_first, w_last;
   logic [7:0]                    r_cnt, r_n, w_n;
   logic                          r_s1_valid, r_s2_valid, r_data_valid;
   logic [CH_NUM*DATA_WIDTH-1:0]  r_data, w_data;

   assign w_stall    = r_data_valid & ~data_ready;
   assign psum_ready = ~w_stall;
   assign w_accept   = psum_valid & psum_ready;
   assign w_first    = r_cnt == 8'd0;
   assign w_n        = w_first ? ((cfg_acc_num == 8'd0) ? 8'd1 : cfg_acc_num) : r_n;
   assign w_last     = r_cnt == w_n - 8'd1;

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      logic signed [ACC_WIDTH-1:0] r_acc, r_s1, w_sum;
      logic signed [ACC_WIDTH:0]   w_bx, w_ax, w_px, w_wide;
      logic signed [PW-1:0]        r_s2, w_rs, w_lo;
      logic signed [SCALE_WIDTH:0] w_scale;
      logic [DATA_WIDTH-1:0]       w_q;
      assign w_bx    = {{(ACC_WIDTH+1-BIAS_WIDTH){cfg_bias[c*BIAS_WIDTH+BIAS_WIDTH-1]}}, cfg_bias[c*BIAS_WIDTH +: BIAS_WIDTH]};
      assign w_px    = {{(ACC_WIDTH+1-PSUM_WIDTH){psum_in[c*PSUM_WIDTH+PSUM_WIDTH-1]}}, psum_in[c*PSUM_WIDTH +: PSUM_WIDTH]};
      assign w_ax    = {r_acc[ACC_WIDTH-1], r_acc};
      assign w_wide  = (w_first ? w_bx : w_ax) + w_px;
      // one guard bit detects overflow; clamp to the signed accumulator range
      assign w_sum   = (w_wide[ACC_WIDTH] == w_wide[ACC_WIDTH-1]) ? w_wide[ACC_WIDTH-1:0]
                     : {w_wide[ACC_WIDTH], {(ACC_WIDTH-1){~w_wide[ACC_WIDTH]}}};
      assign w_scale = {1'b0, cfg_scale[c*SCALE_WIDTH +: SCALE_WIDTH]};
`ifdef NPU_REQUANT_ROUND_EN
      logic signed [PW-1:0] w_rnd;
      assign w_rnd   = (cfg_shift == '0) ? '0 : ({{(PW-1){1'b0}}, 1'b1} <<< (cfg_shift - SHIFT_WIDTH'(1)));
      assign w_rs    = (r_s2 + w_rnd) >>> cfg_shift;
`else
      assign w_rs    = r_s2 >>> cfg_shift;
`endif
      assign w_lo    = cfg_relu ? '0 : L_MIN;
      assign w_q     = (w_rs > L_MAX) ? L_MAX[DATA_WIDTH-1:0] : (w_rs < w_lo) ? w_lo[DATA_WIDTH-1:0] : w_rs[DATA_WIDTH-1:0];
      assign w_data[c*DATA_WIDTH +: DATA_WIDTH] = w_q;
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            r_acc <= '0;
            r_s1  <= '0;
            r_s2  <= '0;
         end else begin
            if (w_accept & ~w_last) r_acc <= w_sum;
            if (w_accept & w_last) r_s1 <= w_sum;
            if (!w_stall) r_s2 <= PW'(r_s1) * PW'(w_scale);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt        <= '0;
         r_n          <= '0;
         r_s1_valid   <= 1'b0;
         r_s2_valid   <= 1'b0;
         r_data_valid <= 1'b0;
         r_data       <= '0;
      end else begin
         if (w_accept) r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
         if (w_accept & w_first) r_n <= w_n;
         if (!w_stall) begin
            r_s1_valid   <= w_accept & w_last;
            r_s2_valid   <= r_s1_valid;
            r_data_valid <= r_s2_valid;
            r_data       <= w_data;
         end
      end
   end

   assign data_out   = r_data;
   assign data_valid = r_data_valid;
   assign busy       = (r_cnt != 8'd0) | r_s1_valid | r_s2_valid | r_data_valid;
endmodule

// File: tb/tb_npu_acc_requant.sv
// tb_npu_acc_requant: directed vector table plus latency, multi-beat, backpressure and mid-group reset sequences.
module tb_npu_acc_requant;
   localparam int CH = 18, PSW = 24, BW = 16, SW = 16, SHW = 5, DW = 8, OW = CH*DW;

   logic              clk = 1'b0;
   logic              rstn;
   logic [CH*PSW-1:0] psum_in;
   logic              psum_valid, psum_ready;
   logic [7:0]        cfg_acc_num;
   logic [CH*BW-1:0]  cfg_bias;
   logic [CH*SW-1:0]  cfg_scale;
   logic [SHW-1:0]    cfg_shift;
   logic              cfg_relu;
   logic [OW-1:0]     data_out;
   logic              data_valid, data_ready, busy;

   int nvec = 0, nfail = 0;

   npu_acc_requant dut (
      .clk(clk), .rstn(rstn), .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(psum_ready),
      .cfg_acc_num(cfg_acc_num), .cfg_bias(cfg_bias), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
      .cfg_relu(cfg_relu), .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int n, p0, b0, s0, p1, b1, s1, sh, relu, e0r, e1r, e0t, e1t;
   } vec_t;
   vec_t tbl[9];

   task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [OW-1:0] pack(input int e0, input int e1);
      logic [OW-1:0] r;
      for (int c = 0; c < CH; c++) r[c*DW +: DW] = (c % 2 == 0) ? DW'(e0) : DW'(e1);
      return r;
   endfunction

   task automatic cfg_set(input int n, input int b0, input int s0, input int b1, input int s1, input int sh, input int relu);
      cfg_acc_num = 8'(n);
      for (int c = 0; c < CH; c++) begin
         cfg_bias[c*BW +: BW]  = (c % 2 == 0) ? BW'(b0) : BW'(b1);
         cfg_scale[c*SW +: SW] = (c % 2 == 0) ? SW'(s0) : SW'(s1);
      end
      cfg_shift = SHW'(sh);
      cfg_relu  = 1'(relu);
   endtask

   task automatic beat(input int p0, input int p1);
      bit ok;
      int k;
      for (int c = 0; c < CH; c++) psum_in[c*PSW +: PSW] = (c % 2 == 0) ? PSW'(p0) : PSW'(p1);
      psum_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         ok = psum_ready;
         @(posedge clk);
         #1;
         k++;
      end while (!ok && k < 50);
      psum_valid = 1'b0;
      if (!ok) check("beat_accept_timeout", OW'(0), OW'(1));
   endtask

   task automatic wait_res(output int k);
      k = 0;
      while (!data_valid && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (!data_valid) check("result_timeout", OW'(0), OW'(1));
   endtask

   initial begin
      int k, e0, e1;
      tbl[0] = '{1,  100,  20,    1,     0,   0,     0,  0, 0,  120,    0,  120,    0};
      tbl[1] = '{1,   46,   0,    1,    -5,   0,     2,  2, 0,   12,   -2,   11,   -3};
      tbl[2] = '{0,   -5,   0,    1,     7,   0,     1,  1, 0,   -2,    4,   -3,    3};
      tbl[3] = '{1,  -50,   0,    1,    90,   0,     1,  0, 1,    0,   90,    0,   90};
      tbl[4] = '{1,  -50,   0,    1,    90,   0,     1,  0, 0,  -50,   90,  -50,   90};
      tbl[5] = '{1, 1000,   0,    1, -1000,   0,     1,  0, 0,  127, -128,  127, -128};
      tbl[6] = '{1,  300, -44, 1000,    -1,   0, 65535, 11, 0,  125,  -32,  125,  -32};
      tbl[7] = '{1,-1000,   0,    1,   200, -73,     1,  0, 1,    0,  127,    0,  127};
      tbl[8] = '{1,    6,   0,    1,    -6,   0,     1,  2, 0,    2,   -1,    1,   -2};

      rstn = 1'b0; psum_valid = 1'b0; data_ready = 1'b1; psum_in = '0;
      cfg_set(1, 0, 1, 0, 1, 0, 0);
      #23;
      check("reset_data_valid", OW'(data_valid), OW'(0));
      check("reset_busy", OW'(busy), OW'(0));
      check("reset_data_out", data_out, '0);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      check("psum_ready_after_reset", OW'(psum_ready), OW'(1));

      cfg_set(1, 20, 1, 0, 0, 0, 0);
      beat(100, 0);
      k = 0;
      while (!data_valid && k < 10) begin
         @(posedge clk); #1; k++;
      end
      check("latency_edges_after_accept", OW'(k), OW'(2));
      check("latency_value", data_out, pack(120, 0));
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
`ifdef NPU_REQUANT_ROUND_EN
         e0 = tbl[i].e0r; e1 = tbl[i].e1r;
`else
         e0 = tbl[i].e0t; e1 = tbl[i].e1t;
`endif
         cfg_set(tbl[i].n, tbl[i].b0, tbl[i].s0, tbl[i].b1, tbl[i].s1, tbl[i].sh, tbl[i].relu);
         beat(tbl[i].p0, tbl[i].p1);
         wait_res(k);
         check($sformatf("vec%0d", i), data_out, pack(e0, e1));
         @(posedge clk); #1;
      end

      cfg_set(3, 0, 3, -10, 2, 2, 0);
      beat(50, -100);
      check("n3_busy_mid_group", OW'(busy), OW'(1));
      beat(60, -100);
      repeat (3) @(posedge clk);
      #1;
      check("n3_no_early_result", OW'(data_valid), OW'(0));
      beat(70, -100);
      wait_res(k);
      check("n3_saturate", data_out, pack(127, -128));
      @(posedge clk); #1;
      check("n3_drained_valid", OW'(data_valid), OW'(0));
      check("n3_idle_busy", OW'(busy), OW'(0));

      data_ready = 1'b0;
      cfg_set(1, 0, 1, 0, 1, 0, 0);
      fork
         begin
            for (int b = 1; b <= 4; b++) beat(b, -b);
         end
         begin
            logic [OW-1:0] hold;
            logic [OW-1:0] res[4];
            int t, got;
            t = 0;
            do begin
               @(negedge clk); t++;
            end while (!data_valid && t < 20);
            hold = data_out;
            for (int i = 0; i < 6; i++) begin
               check("bp_data_held", data_out, hold);
               check("bp_psum_ready_low", OW'(psum_ready), OW'(0));
               @(negedge clk);
            end
            data_ready = 1'b1;
            got = 0; t = 0;
            while (got < 4 && t < 30) begin
               if (data_valid) begin
                  res[got] = data_out; got++;
               end
               @(negedge clk); t++;
            end
            check("bp_result_count", OW'(got), OW'(4));
            for (int i = 0; i < got; i++) check($sformatf("bp_result%0d", i), res[i], pack(i + 1, -(i + 1)));
         end
      join
      @(posedge clk); #1;

      cfg_set(4, 0, 1, 0, 1, 0, 0);
      beat(7, 7);
      beat(7, 7);
      check("rst_busy_before", OW'(busy), OW'(1));
      #2 rstn = 1'b0;
      #1;
      check("rst_data_valid", OW'(data_valid), OW'(0));
      check("rst_busy", OW'(busy), OW'(0));
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      cfg_set(4, 0, 1, 0, 1, 0, 0);
      repeat (4) beat(10, 10);
      wait_res(k);
      check("rst_fresh_group", data_out, pack(40, 40));
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
